// File: rtl/config_regbank_scan.sv
// Configuration register bank with shadow/active double buffering, atomic commit and
// sticky write lock, plus a registered monitor mux with manual or auto-scan selection.
module config_regbank_scan #(
  parameter int AW      = 2,
  parameter int DW      = 16,
  parameter int NCH     = 8,
  parameter int CW      = 6,
  parameter int SELW    = 3,
  parameter int DWELL_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   reg_wr_i,
  input  logic [AW-1:0]          reg_adr_i,
  input  logic [DW-1:0]          reg_dat_i,
  input  logic                   commit_i,
  input  logic                   lock_i,
  output logic [(2**AW)*DW-1:0]  cfg_o,
  output logic [DW-1:0]          reg_rd_o,
  output logic                   pending_o,
  output logic                   locked_o,
  output logic                   wr_err_o,
  input  logic [NCH*CW-1:0]      mux_i,
  input  logic                   scan_en_i,
  input  logic [SELW-1:0]        mux_adr_i,
  input  logic [DWELL_W-1:0]     dwell_i,
  output logic [CW-1:0]          mux_o,
  output logic [SELW-1:0]        mux_sel_o,
  output logic                   mux_vld_o
);

  localparam int NREG = 2**AW;

  typedef enum logic {MUX_MANUAL, MUX_SCAN} mux_state_e;

  logic [DW-1:0]      shadow_q [NREG];
  logic [DW-1:0]      shadow_d [NREG];
  logic [NREG*DW-1:0] cfg_q, cfg_d;
  logic               pending_q, pending_d;
  logic               locked_q, locked_d;
  logic               wr_err_q, wr_err_d;

  mux_state_e         state_q, state_d;
  logic [SELW-1:0]    scan_sel_q, scan_sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]      mux_q, mux_d;
  logic [SELW-1:0]    mux_sel_q, mux_sel_d;
  logic               vld_q, vld_d;

  // Out-of-range channel indices read as zero.
  function automatic logic [CW-1:0] pick(input logic [NCH*CW-1:0] ch,
                                         input logic [SELW-1:0]   idx);
    pick = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (idx == SELW'(n)) pick = ch[n*CW +: CW];
    end
  endfunction

  // Commit is evaluated before the write so it always captures the pre-edge shadow.
  always_comb begin
    shadow_d  = shadow_q;
    cfg_d     = cfg_q;
    pending_d = pending_q;
    locked_d  = locked_q | lock_i;
    wr_err_d  = 1'b0;
    if (commit_i) begin
      for (int unsigned n = 0; n < NREG; n++) cfg_d[n*DW +: DW] = shadow_q[n];
      pending_d = 1'b0;
    end
    if (reg_wr_i) begin
      if (locked_q) begin
        wr_err_d = 1'b1;
      end else begin
        shadow_d[reg_adr_i] = reg_dat_i;
        pending_d           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q  <= '{default: '0};
      cfg_q     <= '0;
      pending_q <= 1'b0;
      locked_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      cfg_q     <= cfg_d;
      pending_q <= pending_d;
      locked_q  <= locked_d;
      wr_err_q  <= wr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_sel_d = scan_sel_q;
    cnt_d      = cnt_q;
    mux_d      = mux_q;
    mux_sel_d  = mux_sel_q;
    vld_d      = 1'b0;
    case (state_q)
      MUX_MANUAL: begin
        mux_d     = pick(mux_i, mux_adr_i);
        mux_sel_d = mux_adr_i;
        if (scan_en_i) begin
          state_d    = MUX_SCAN;
          scan_sel_d = '0;
          cnt_d      = dwell_i;
        end
      end
      MUX_SCAN: begin
        if (!scan_en_i) begin
          state_d   = MUX_MANUAL;
          mux_d     = pick(mux_i, mux_adr_i);
          mux_sel_d = mux_adr_i;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          mux_d      = pick(mux_i, scan_sel_q);
          mux_sel_d  = scan_sel_q;
          vld_d      = 1'b1;
          scan_sel_d = (scan_sel_q == SELW'(NCH - 1)) ? '0 : scan_sel_q + SELW'(1);
          cnt_d      = dwell_i;
        end
      end
      default: state_d = MUX_MANUAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= MUX_MANUAL;
      scan_sel_q <= '0;
      cnt_q      <= '0;
      mux_q      <= '0;
      mux_sel_q  <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_sel_q <= scan_sel_d;
      cnt_q      <= cnt_d;
      mux_q      <= mux_d;
      mux_sel_q  <= mux_sel_d;
      vld_q      <= vld_d;
    end
  end

  assign cfg_o     = cfg_q;
  assign reg_rd_o  = shadow_q[reg_adr_i];
  assign pending_o = pending_q;
  assign locked_o  = locked_q;
  assign wr_err_o  = wr_err_q;
  assign mux_o     = mux_q;
  assign mux_sel_o = mux_sel_q;
  assign mux_vld_o = vld_q;

endmodule

// File: tb/tb_config_regbank_scan.sv
// Directed + randomized bench for config_regbank_scan against a behavioural model.
module tb_config_regbank_scan;

  localparam int AW = 2, DW = 16, NCH = 8, CW = 6, SELW = 3, DWW = 8, NREG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, reg_wr, commit, lock, scan_en;
  logic [AW-1:0]        reg_adr;
  logic [DW-1:0]        reg_dat;
  logic [NCH*CW-1:0]    mux_v;
  logic [SELW-1:0]      mux_adr;
  logic [DWW-1:0]       dwell;
  logic [NREG*DW-1:0]   cfg_o;
  logic [DW-1:0]        reg_rd_o;
  logic                 pending_o, locked_o, wr_err_o, mux_vld_o;
  logic [CW-1:0]        mux_o;
  logic [SELW-1:0]      mux_sel_o;

  config_regbank_scan #(.AW(AW), .DW(DW), .NCH(NCH), .CW(CW), .SELW(SELW), .DWELL_W(DWW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .reg_wr_i(reg_wr), .reg_adr_i(reg_adr),
    .reg_dat_i(reg_dat), .commit_i(commit), .lock_i(lock), .cfg_o(cfg_o),
    .reg_rd_o(reg_rd_o), .pending_o(pending_o), .locked_o(locked_o), .wr_err_o(wr_err_o),
    .mux_i(mux_v), .scan_en_i(scan_en), .mux_adr_i(mux_adr), .dwell_i(dwell),
    .mux_o(mux_o), .mux_sel_o(mux_sel_o), .mux_vld_o(mux_vld_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] sh_m [NREG];
  logic [DW-1:0] cf_m [NREG];
  bit            pend_m, lck_m, werr_m;
  bit            scan_m;
  int            t_m, d_m;
  logic [CW-1:0] mux_m;
  int            sel_m;
  bit            vld_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] chv(input logic [NCH*CW-1:0] v, input int i);
    if (i >= NCH) return '0;
    return v[i*CW +: CW];
  endfunction

  function automatic logic [63:0] cfg_pack();
    logic [63:0] r;
    for (int i = 0; i < NREG; i++) r[i*DW +: DW] = cf_m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin sh_m[i] = '0; cf_m[i] = '0; end
    pend_m = 0; lck_m = 0; werr_m = 0;
    scan_m = 0; t_m = 0; d_m = 0; mux_m = '0; sel_m = 0; vld_m = 0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".cfg"},     cfg_o,            cfg_pack());
    check({ph, ".rd"},      64'(reg_rd_o),    64'(sh_m[reg_adr]));
    check({ph, ".pending"}, 64'(pending_o),   64'(pend_m));
    check({ph, ".locked"},  64'(locked_o),    64'(lck_m));
    check({ph, ".wr_err"},  64'(wr_err_o),    64'(werr_m));
    check({ph, ".mux"},     64'(mux_o),       64'(mux_m));
    check({ph, ".sel"},     64'(mux_sel_o),   64'(sel_m));
    check({ph, ".vld"},     64'(mux_vld_o),   64'(vld_m));
  endtask

  // One clock edge: the model consumes the inputs as they stood before the edge.
  task automatic tick(input string ph);
    logic          wr = reg_wr, cm = commit, lk = lock, se = scan_en;
    logic [AW-1:0] ad = reg_adr;
    logic [DW-1:0] dt = reg_dat;
    logic [NCH*CW-1:0] ch = mux_v;
    int            ma = int'(mux_adr);
    int            dw = int'(dwell);
    int            k;
    @(posedge clk);
    #1;
    werr_m = wr && lck_m;
    if (cm) begin
      for (int i = 0; i < NREG; i++) cf_m[i] = sh_m[i];
      pend_m = 0;
    end
    if (wr && !lck_m) begin sh_m[ad] = dt; pend_m = 1; end
    if (lk) lck_m = 1;
    vld_m = 0;
    if (scan_m && se) begin
      t_m++;
      if (t_m % (d_m + 1) == 0) begin
        k     = t_m / (d_m + 1);
        sel_m = (k - 1) % NCH;
        mux_m = chv(ch, sel_m);
        vld_m = 1;
      end
    end else begin
      mux_m = chv(ch, ma);
      sel_m = ma;
      if (!scan_m && se) begin scan_m = 1; t_m = 0; d_m = dw; end
      else scan_m = 0;
    end
    check_all(ph);
  endtask

  task automatic rand_cfg(input bit allow_lock);
    reg_wr  = 1'($urandom_range(0, 1));
    reg_adr = AW'($urandom);
    reg_dat = DW'($urandom);
    commit  = ($urandom_range(0, 3) == 0);
    lock    = allow_lock && ($urandom_range(0, 15) == 0);
  endtask

  task automatic idle_cfg();
    reg_wr = 0; commit = 0; lock = 0;
  endtask

  task automatic ramp_channels();
    for (int i = 0; i < NCH; i++) mux_v[i*CW +: CW] = CW'(i + 10);
  endtask

  int            vc;
  logic [DW-1:0] saved;

  initial begin
    rst_n = 0; reg_wr = 0; reg_adr = '0; reg_dat = '0; commit = 0; lock = 0;
    scan_en = 0; mux_adr = '0; dwell = '0; mux_v = NCH*CW'($urandom);
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1;
    #1;
    check_all("reset");

    // Shadow write then commit
    reg_wr = 1; reg_adr = 2; reg_dat = 16'hA5A5;
    tick("t2w");
    reg_wr = 0;
    #0;
    check("t2.rd", 64'(reg_rd_o), 64'h A5A5);
    check("t2.cfg2_old", 64'(cfg_o[2*DW +: DW]), 64'h0);
    check("t2.pend1", 64'(pending_o), 64'h1);
    commit = 1;
    tick("t2c");
    commit = 0;
    check("t2.cfg2_new", 64'(cfg_o[2*DW +: DW]), 64'hA5A5);
    check("t2.pend0", 64'(pending_o), 64'h0);

    // Write and commit in the same cycle
    reg_wr = 1; reg_adr = 1; reg_dat = 16'h1111;
    tick("t3a");
    commit = 1; reg_dat = 16'h2222;
    tick("t3b");
    idle_cfg();
    check("t3.cfg1", 64'(cfg_o[1*DW +: DW]), 64'h1111);
    check("t3.rd1", 64'(reg_rd_o), 64'h2222);
    check("t3.pend", 64'(pending_o), 64'h1);

    // Random unlocked traffic with random manual mux selection
    for (int i = 0; i < 40; i++) begin
      rand_cfg(0);
      mux_v   = NCH*CW'({$urandom, $urandom});
      mux_adr = SELW'($urandom);
      tick("rnd_cfg");
    end
    idle_cfg();

    // Sticky lock rejects writes but commits still work
    lock = 1;
    tick("t4lock");
    lock = 0;
    saved = sh_m[0];
    reg_wr = 1; reg_adr = 0; reg_dat = 16'hFFFF;
    tick("t4w");
    reg_wr = 0;
    check("t4.err", 64'(wr_err_o), 64'h1);
    check("t4.locked", 64'(locked_o), 64'h1);
    check("t4.rd0", 64'(reg_rd_o), 64'(saved));
    tick("t4idle");
    check("t4.err_pulse", 64'(wr_err_o), 64'h0);
    commit = 1;
    tick("t4c");
    commit = 0;
    check("t4.cfg0", 64'(cfg_o[0 +: DW]), 64'(saved));
    for (int i = 0; i < 20; i++) begin
      rand_cfg(1);
      tick("rnd_lock");
    end
    idle_cfg();

    // Manual selection latency
    ramp_channels();
    mux_adr = 5;
    tick("t6m");
    check("t6.mux", 64'(mux_o), 64'd15);
    check("t6.vld", 64'(mux_vld_o), 64'h0);

    // Scan with dwell 2: nine samples over 27 cycles, first is ch0
    scan_en = 1; dwell = 2;
    tick("t5entry");
    vc = 0;
    for (int i = 0; i < 27; i++) begin
      tick("t5d2");
      if (i == 2) begin
        check("t5.first_mux", 64'(mux_o), 64'd10);
        check("t5.first_vld", 64'(mux_vld_o), 64'h1);
      end
      if (mux_vld_o) vc++;
    end
    check("t5.count_d2", 64'(vc), 64'd9);
    check("t5.wrap_sel", 64'(mux_sel_o), 64'd0);
    check("t5.wrap_mux", 64'(mux_o), 64'd10);

    // Dwell 0: a sample every cycle
    scan_en = 0;
    tick("t5exit");
    scan_en = 1; dwell = 0;
    tick("t5entry0");
    vc = 0;
    for (int i = 0; i < 8; i++) begin
      tick("t5d0");
      if (mux_vld_o) vc++;
    end
    check("t5.count_d0", 64'(vc), 64'd8);

    // Leave scan mid-dwell
    scan_en = 0;
    tick("t6exit0");
    scan_en = 1; dwell = 4;
    tick("t6entry");
    tick("t6dw1");
    tick("t6dw2");
    scan_en = 0; mux_adr = 3;
    tick("t6leave");
    check("t6.leave_vld", 64'(mux_vld_o), 64'h0);
    check("t6.leave_mux", 64'(mux_o), 64'd13);

    // Random mux/scan traffic with config traffic in parallel
    for (int i = 0; i < 300; i++) begin
      rand_cfg(0);
      mux_v   = NCH*CW'({$urandom, $urandom});
      mux_adr = SELW'($urandom);
      if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
      if (!scan_en) dwell = DWW'($urandom_range(0, 4));
      tick("rnd_mux");
    end

    // Asynchronous reset mid-scan
    idle_cfg();
    scan_en = 1; dwell = 1;
    tick("t1entry");
    tick("t1s1");
    tick("t1s2");
    rand_cfg(1);
    mux_adr = SELW'($urandom);
    #2;
    rst_n = 0;
    #1;
    check("t1.cfg", cfg_o, 64'h0);
    check("t1.pend", 64'(pending_o), 64'h0);
    check("t1.locked", 64'(locked_o), 64'h0);
    check("t1.err", 64'(wr_err_o), 64'h0);
    check("t1.mux", 64'(mux_o), 64'h0);
    check("t1.sel", 64'(mux_sel_o), 64'h0);
    check("t1.vld", 64'(mux_vld_o), 64'h0);
    check("t1.rd", 64'(reg_rd_o), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      rand_cfg(1);
      mux_v = NCH*CW'({$urandom, $urandom});
      tick("post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
